// File: rtl/picorv32_sim_pkg.sv
// Shared types and constants for the PicoRV32 run supervisor.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package picorv32_sim_pkg;

    // Supervisor sequencing states.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } sup_state_e;

    // Width of the saturating run-cycle counter.
    localparam int CYCLE_W = 32;

    function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Smallest w with 2**w >= max_val. A counter of this width can reach
    // every compare value the supervisor needs (all of them are < max_val).
    function automatic int cnt_width_req(input longint unsigned max_val);
        int w;
        w = 0;
        for (int k = 0; k < 63; k++) begin
            if ((64'd1 << k) < max_val) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/picorv32_run_supervisor_if.sv
// Control/status bundle between the run supervisor and the supervised cores/harness.
// Latency: n/a (wires only); every supervisor-driven signal comes straight from a register.
// Backpressure: none; strobes and levels are sampled every clock.
// master: supervisor side (samples restart/activity/trap, drives resets and status).
// slave : harness side (drives restart/activity/trap, observes resets and status).
interface picorv32_run_supervisor_if #(
    parameter int NUM_CORES = 1
);
    logic                                   restart;
    logic [NUM_CORES-1:0]                   activity;
    logic [NUM_CORES-1:0]                   trap;
    logic [NUM_CORES-1:0]                   core_resetn;
    logic                                   running;
    logic                                   done;
    logic                                   timeout;
    logic [NUM_CORES-1:0]                   trap_mask;
    logic [picorv32_sim_pkg::CYCLE_W-1:0]   cycle_count;

    modport master (
        input  restart, activity, trap,
        output core_resetn, running, done, timeout, trap_mask, cycle_count
    );

    modport slave (
        output restart, activity, trap,
        input  core_resetn, running, done, timeout, trap_mask, cycle_count
    );
endinterface

// File: rtl/picorv32_sup_counter.sv
// Saturating up-counter with synchronous clear, enable and a terminal-value match flag.
// Latency: count updates one clock after en_i/clr_i; match_o decodes the registered count.
// Backpressure: none; clr_i dominates en_i, and the count holds at all-ones.
// Ports: clk_i, rst_ni (async active-low), clr_i, en_i, cnt_o (current count), match_o (cnt_o == MATCH).
module picorv32_sup_counter #(
    parameter int               WIDTH = 20,
    parameter logic [WIDTH-1:0] MATCH = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             match_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign match_o = (cnt_q == MATCH);

endmodule

// File: rtl/picorv32_run_supervisor.sv
// Run controller: staggered per-core reset release, trap/timeout watch, sticky status, soft restart.
// Latency: every output is registered; an input change is visible one clock later.
// Backpressure: none; restart/activity/trap are sampled every clock, restart overrides all states.
// Ports: clk, resetn (async active-low), bus (master modport: restart, activity, trap in;
//        core_resetn, running, done, timeout, trap_mask, cycle_count out).
module picorv32_run_supervisor
    import picorv32_sim_pkg::*;
#(
    parameter int NUM_CORES      = 1,
    parameter int RESET_CYCLES   = 100,
    parameter int STAGGER_CYCLES = 0,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int KICK_MODE      = 0,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                        clk,
    input  logic                        resetn,
    picorv32_run_supervisor_if.master   bus
);

    // Last hold value that has to be reachable: release point of the final core.
    localparam longint unsigned HOLD_SPAN =
        longint'(RESET_CYCLES) + longint'(NUM_CORES - 1) * longint'(STAGGER_CYCLES);
    localparam longint unsigned CNT_SPAN  = max2(longint'(TIMEOUT_CYCLES), HOLD_SPAN);

    if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_cores
        $error("picorv32_run_supervisor: NUM_CORES must be 1..8");
    end
    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STAGGER_CYCLES < 0) begin : g_bad_cycles
        $error("picorv32_run_supervisor: RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end
    if (CNT_WIDTH < cnt_width_req(CNT_SPAN)) begin : g_bad_width
        $error("picorv32_run_supervisor: CNT_WIDTH too small for hold/timeout span");
    end

    sup_state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]       core_rel_q, core_rel_d;
    logic [NUM_CORES-1:0]       trap_mask_q, trap_mask_d;
    logic [CYCLE_W-1:0]         cyc_q, cyc_d;

    logic [CNT_WIDTH-1:0]       hold_cnt;
    logic                       hold_first;   // hold_cnt at core 0 release point
    logic                       hold_en;
    logic [NUM_CORES-1:0]       rel_hit;      // per-core release point reached this edge
    logic [CNT_WIDTH-1:0]       tmo_cnt_unused;
    logic                       tmo_last;     // tmo_cnt at TIMEOUT_CYCLES-1
    logic                       tmo_en;
    logic                       kick;

    picorv32_sup_counter #(
        .WIDTH (CNT_WIDTH),
        .MATCH (CNT_WIDTH'(RESET_CYCLES - 1))
    ) u_hold_cnt (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .clr_i   (bus.restart),
        .en_i    (hold_en),
        .cnt_o   (hold_cnt),
        .match_o (hold_first)
    );

    // A kick clears the watchdog on the same edge, so the expiry compare only
    // fires after TIMEOUT_CYCLES edges with no activity.
    picorv32_sup_counter #(
        .WIDTH (CNT_WIDTH),
        .MATCH (CNT_WIDTH'(TIMEOUT_CYCLES - 1))
    ) u_tmo_cnt (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .clr_i   (bus.restart | kick),
        .en_i    (tmo_en),
        .cnt_o   (tmo_cnt_unused),
        .match_o (tmo_last)
    );

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_rel
        localparam logic [CNT_WIDTH-1:0] REL_AT = CNT_WIDTH'(RESET_CYCLES - 1 + i * STAGGER_CYCLES);
        assign rel_hit[i] = (hold_cnt == REL_AT);
    end

    always_comb begin
        state_d     = state_q;
        core_rel_d  = core_rel_q;
        trap_mask_d = trap_mask_q;
        cyc_d       = cyc_q;
        hold_en     = 1'b0;
        tmo_en      = 1'b0;
        kick        = 1'b0;

        if (bus.restart) begin
            state_d     = ST_HOLD;
            core_rel_d  = '0;
            trap_mask_d = '0;
            cyc_d       = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    hold_en    = 1'b1;
                    core_rel_d = core_rel_q | rel_hit;
                    if (hold_first) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Staggered releases continue into RUN; the hold count
                    // freezes once the last core is out of reset.
                    hold_en = !core_rel_q[NUM_CORES-1];
                    if (hold_en) begin
                        core_rel_d = core_rel_q | rel_hit;
                    end
                    cyc_d       = (cyc_q == '1) ? cyc_q : cyc_q + CYCLE_W'(1);
                    tmo_en      = 1'b1;
                    kick        = (KICK_MODE != 0) && |(bus.activity & core_rel_q);
                    trap_mask_d = trap_mask_q | (bus.trap & core_rel_q);
                    // All-trapped takes priority over a coincident expiry.
                    if (&trap_mask_d) begin
                        state_d = ST_DONE;
                    end else if (tmo_last && !kick) begin
                        state_d    = ST_TMO;
                        core_rel_d = '0;
                    end
                end
                ST_DONE, ST_TMO: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_HOLD;
            core_rel_q  <= '0;
            trap_mask_q <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            core_rel_q  <= core_rel_d;
            trap_mask_q <= trap_mask_d;
            cyc_q       <= cyc_d;
        end
    end

    assign bus.core_resetn = core_rel_q;
    assign bus.running     = (state_q == ST_RUN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.timeout     = (state_q == ST_TMO);
    assign bus.trap_mask   = trap_mask_q;
    assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_picorv32_run_supervisor.sv
// Directed bench for picorv32_run_supervisor: five configurations sharing one clock.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_picorv32_run_supervisor;

    logic clk;
    logic r1, r2, r3, r4, r5;
    int   n_chk;
    int   n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    picorv32_run_supervisor_if #(.NUM_CORES(1)) if1 ();
    picorv32_run_supervisor_if #(.NUM_CORES(1)) if2 ();
    picorv32_run_supervisor_if #(.NUM_CORES(1)) if3 ();
    picorv32_run_supervisor_if #(.NUM_CORES(3)) if4 ();
    picorv32_run_supervisor_if #(.NUM_CORES(2)) if5 ();

    // Defaults.
    picorv32_run_supervisor u1 (.clk(clk), .resetn(r1), .bus(if1));
    // Absolute timeout of 50; also used for restart/reset sequencing.
    picorv32_run_supervisor #(.TIMEOUT_CYCLES(50)) u2 (.clk(clk), .resetn(r2), .bus(if2));
    // Watchdog timeout of 50.
    picorv32_run_supervisor #(.TIMEOUT_CYCLES(50), .KICK_MODE(1)) u3 (.clk(clk), .resetn(r3), .bus(if3));
    // Three cores, staggered release.
    picorv32_run_supervisor #(.NUM_CORES(3), .RESET_CYCLES(20), .STAGGER_CYCLES(10),
                              .TIMEOUT_CYCLES(1000)) u4 (.clk(clk), .resetn(r4), .bus(if4));
    // Two cores, trap and expiry on the same edge.
    picorv32_run_supervisor #(.NUM_CORES(2), .RESET_CYCLES(20), .TIMEOUT_CYCLES(30))
        u5 (.clk(clk), .resetn(r5), .bus(if5));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        {r1, r2, r3, r4, r5} = '0;
        if1.restart = 1'b0; if1.activity = '0; if1.trap = '0;
        if2.restart = 1'b1; if2.activity = '0; if2.trap = '0;
        if3.restart = 1'b0; if3.activity = '0; if3.trap = '0;
        if4.restart = 1'b0; if4.activity = '0; if4.trap = '0;
        if5.restart = 1'b0; if5.activity = '0; if5.trap = '0;
        step(3);

        // Reset state; restart asserted during reset has no effect.
        chk("rst_core_resetn", 32'(if1.core_resetn), 32'd0);
        chk("rst_running",     32'(if1.running),     32'd0);
        chk("rst_done",        32'(if1.done),        32'd0);
        chk("rst_timeout",     32'(if1.timeout),     32'd0);
        chk("rst_trap_mask",   32'(if1.trap_mask),   32'd0);
        chk("rst_cycle_count", if1.cycle_count,      32'd0);
        chk("rst_restart_running", 32'(if2.running), 32'd0);
        if2.restart = 1'b0;

        // 1: default hold of 100 edges, trap after 500 RUN cycles.
        r1 = 1'b1;
        step(99);
        chk("t1_hold99_core",    32'(if1.core_resetn), 32'd0);
        chk("t1_hold99_running", 32'(if1.running),     32'd0);
        step(1);
        chk("t1_rel100_core",    32'(if1.core_resetn), 32'd1);
        chk("t1_rel100_running", 32'(if1.running),     32'd1);
        step(500);
        chk("t1_cc500",   if1.cycle_count,  32'd500);
        chk("t1_nodone",  32'(if1.done),    32'd0);
        if1.trap = 1'b1;
        step(1);
        if1.trap = 1'b0;
        chk("t1_done",      32'(if1.done),        32'd1);
        chk("t1_cc501",     if1.cycle_count,      32'd501);
        chk("t1_timeout",   32'(if1.timeout),     32'd0);
        chk("t1_running",   32'(if1.running),     32'd0);
        chk("t1_trap_mask", 32'(if1.trap_mask),   32'd1);
        chk("t1_core_kept", 32'(if1.core_resetn), 32'd1);
        step(3);
        chk("t1_cc_frozen", if1.cycle_count,      32'd501);

        // 2: absolute timeout after 50 RUN edges.
        r2 = 1'b1;
        step(100);
        chk("t2_running", 32'(if2.running), 32'd1);
        step(49);
        chk("t2_tmo49",   32'(if2.timeout),  32'd0);
        chk("t2_cc49",    if2.cycle_count,   32'd49);
        step(1);
        chk("t2_tmo50",     32'(if2.timeout),     32'd1);
        chk("t2_core_off",  32'(if2.core_resetn), 32'd0);
        chk("t2_nodone",    32'(if2.done),        32'd0);
        chk("t2_cc50",      if2.cycle_count,      32'd50);
        chk("t2_notrun",    32'(if2.running),     32'd0);
        step(5);
        chk("t2_cc_frozen", if2.cycle_count,      32'd50);

        // 6: restart from TMO, restart mid-RUN, then reset mid-HOLD.
        if2.restart = 1'b1;
        step(1);
        if2.restart = 1'b0;
        chk("t6_rs_timeout", 32'(if2.timeout),  32'd0);
        chk("t6_rs_cc",      if2.cycle_count,   32'd0);
        step(99);
        chk("t6_rs_hold99",  32'(if2.core_resetn), 32'd0);
        step(1);
        chk("t6_rs_rel100",  32'(if2.core_resetn), 32'd1);
        step(20);
        chk("t6_run_cc20",   if2.cycle_count,   32'd20);
        if2.restart = 1'b1;
        step(1);
        if2.restart = 1'b0;
        chk("t6_mid_running", 32'(if2.running),     32'd0);
        chk("t6_mid_core",    32'(if2.core_resetn), 32'd0);
        chk("t6_mid_cc",      if2.cycle_count,      32'd0);
        step(60);
        r2 = 1'b0;
        if2.restart = 1'b1;
        #1;
        chk("t6_arst_core",    32'(if2.core_resetn), 32'd0);
        chk("t6_arst_running", 32'(if2.running),     32'd0);
        step(2);
        if2.restart = 1'b0;
        r2 = 1'b1;
        step(99);
        chk("t6_rst_hold99",   32'(if2.core_resetn), 32'd0);
        chk("t6_rst_hold99_r", 32'(if2.running),     32'd0);
        step(1);
        chk("t6_rst_rel100",   32'(if2.core_resetn), 32'd1);
        chk("t6_rst_running",  32'(if2.running),     32'd1);

        // 3: watchdog kicked every 40 cycles for 400 cycles.
        r3 = 1'b1;
        step(100);
        chk("t3_running", 32'(if3.running), 32'd1);
        for (int k = 0; k < 10; k++) begin
            step(39);
            if3.activity = 1'b1;
            step(1);
            if3.activity = 1'b0;
        end
        chk("t3_kicked_notmo", 32'(if3.timeout), 32'd0);
        step(49);
        chk("t3_tmo49",  32'(if3.timeout),  32'd0);
        step(1);
        chk("t3_tmo50",  32'(if3.timeout),  32'd1);
        chk("t3_cc450",  if3.cycle_count,   32'd450);

        // 4: three cores released at edges 20, 30, 40.
        r4 = 1'b1;
        step(19);
        chk("t4_e19_core", 32'(if4.core_resetn), 32'd0);
        step(1);
        chk("t4_e20_core", 32'(if4.core_resetn), 32'b001);
        chk("t4_e20_run",  32'(if4.running),     32'd1);
        step(4);
        if4.trap = 3'b100;
        step(1);
        if4.trap = 3'b000;
        chk("t4_early_trap", 32'(if4.trap_mask), 32'd0);
        step(4);
        chk("t4_e29_core", 32'(if4.core_resetn), 32'b001);
        step(1);
        chk("t4_e30_core", 32'(if4.core_resetn), 32'b011);
        step(9);
        chk("t4_e39_core", 32'(if4.core_resetn), 32'b011);
        step(1);
        chk("t4_e40_core", 32'(if4.core_resetn), 32'b111);
        if4.trap = 3'b001;
        step(1);
        chk("t4_mask1", 32'(if4.trap_mask), 32'b001);
        chk("t4_done1", 32'(if4.done),      32'd0);
        if4.trap = 3'b011;
        step(1);
        chk("t4_mask2", 32'(if4.trap_mask), 32'b011);
        chk("t4_done2", 32'(if4.done),      32'd0);
        if4.trap = 3'b111;
        step(1);
        chk("t4_mask3", 32'(if4.trap_mask), 32'b111);
        chk("t4_done3", 32'(if4.done),      32'd1);
        chk("t4_cc23",  if4.cycle_count,    32'd23);

        // 5: last trap on the expiry edge, DONE wins.
        r5 = 1'b1;
        step(20);
        chk("t5_core", 32'(if5.core_resetn), 32'b11);
        if5.trap = 2'b01;
        step(1);
        chk("t5_mask01", 32'(if5.trap_mask), 32'b01);
        step(28);
        chk("t5_pre_tmo", 32'(if5.timeout), 32'd0);
        if5.trap = 2'b11;
        step(1);
        chk("t5_done",    32'(if5.done),        32'd1);
        chk("t5_timeout", 32'(if5.timeout),     32'd0);
        chk("t5_cc30",    if5.cycle_count,      32'd30);
        chk("t5_core_on", 32'(if5.core_resetn), 32'b11);
        step(2);
        chk("t5_timeout_later", 32'(if5.timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
